// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic-cycle master: one bus transaction per
// command, with read data or an error status returned on a response channel.
module wb_initiator #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic        cmd_byte,
   input  logic [23:0] cmd_adr,
   input  logic [15:0] cmd_dat,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_dat,
   output logic        rsp_err,
   output logic [23:0] wb_adr_o,
   output logic [15:0] wb_dat_o,
   input  logic [15:0] wb_dat_i,
   output logic [1:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic              byte_q, byte_d;
   logic [1:0]        sel_q, sel_d;
   logic [23:0]       adr_q, adr_d;
   logic [15:0]       dat_q, dat_d;
   logic [15:0]       rspDat_q, rspDat_d;
   logic              rspErr_q, rspErr_d;
   logic [7:0]        laneByte;

   assign laneByte = adr_q[0] ? wb_dat_i[15:8] : wb_dat_i[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         byte_q   <= 1'b0;
         sel_q    <= 2'b00;
         adr_q    <= '0;
         dat_q    <= '0;
         rspDat_q <= '0;
         rspErr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         byte_q   <= byte_d;
         sel_q    <= sel_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         rspDat_q <= rspDat_d;
         rspErr_q <= rspErr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      byte_d   = byte_q;
      sel_d    = sel_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      rspDat_d = rspDat_q;
      rspErr_d = rspErr_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               rspDat_d = '0;
               // A misaligned word access never reaches the bus.
               if (!cmd_byte && cmd_adr[0]) begin
                  rspErr_d = 1'b1;
                  state_d  = RESP;
               end else begin
                  rspErr_d = 1'b0;
                  cyc_d    = 1'b1;
                  adr_d    = cmd_adr;
                  we_d     = cmd_we;
                  byte_d   = cmd_byte;
                  cnt_d    = '0;
                  sel_d    = cmd_byte ? (cmd_adr[0] ? 2'b10 : 2'b01) : 2'b11;
                  dat_d    = cmd_byte ? {cmd_dat[7:0], cmd_dat[7:0]} : cmd_dat;
                  state_d  = BUS;
               end
            end
         end
         BUS: begin
            if (wb_err_i || wb_ack_i || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               sel_d   = 2'b00;
               state_d = RESP;
               if (!wb_err_i && wb_ack_i) begin
                  rspErr_d = 1'b0;
                  if (we_q)
                     rspDat_d = '0;
                  else if (byte_q)
                     rspDat_d = {8'h00, laneByte};
                  else
                     rspDat_d = wb_dat_i;
               end else begin
                  rspErr_d = 1'b1;
                  rspDat_d = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_dat   = rspDat_q;
   assign rsp_err   = rspErr_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;
   assign wb_sel_o  = sel_q;
   assign wb_we_o   = we_q;
   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: drives commands against a small registered
// byte-lane RAM slave, with no-ack and ack+err slave modes.
module tb_wb_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we, cmd_byte;
   logic [23:0] cmd_adr;
   logic [15:0] cmd_dat;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [15:0] rsp_dat;
   logic [23:0] wb_adr_o;
   logic [15:0] wb_dat_o, wb_dat_i;
   logic [1:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

   int nVec = 0;
   int nFail = 0;
   int cycCount = 0;
   int slaveMode = 0;
   logic [7:0] mem [0:255];

   always #5 clk = ~clk;

   wb_initiator #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_byte(cmd_byte), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   // Zero-wait registered slave: mode 0 = RAM, 1 = silent, 2 = ack and err together.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_ack_i <= 1'b0;
         wb_err_i <= 1'b0;
         wb_dat_i <= '0;
      end else begin
         wb_ack_i <= 1'b0;
         wb_err_i <= 1'b0;
         if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
            if (slaveMode == 0) begin
               wb_ack_i <= 1'b1;
               if (wb_we_o) begin
                  if (wb_sel_o[0]) mem[{wb_adr_o[7:1], 1'b0}] <= wb_dat_o[7:0];
                  if (wb_sel_o[1]) mem[{wb_adr_o[7:1], 1'b1}] <= wb_dat_o[15:8];
               end else begin
                  wb_dat_i <= {mem[{wb_adr_o[7:1], 1'b1}], mem[{wb_adr_o[7:1], 1'b0}]};
               end
            end else if (slaveMode == 2) begin
               wb_ack_i <= 1'b1;
               wb_err_i <= 1'b1;
               wb_dat_i <= 16'h1234;
            end
         end
      end
   end

   always @(negedge clk) if (wb_cyc_o) cycCount++;

   // Presents a command from a negedge and returns at the negedge after the accept edge.
   task automatic applyStimulus(input logic we, input logic byteAcc,
                                input logic [23:0] adr, input logic [15:0] dat);
      int n;
      cmd_we = we; cmd_byte = byteAcc; cmd_adr = adr; cmd_dat = dat;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      nVec++;
      if (cmd_ready !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL cmd_accept: cmd_ready=%b, expected 1", cmd_ready);
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_we = ~we; cmd_byte = ~byteAcc; cmd_adr = 24'hFFFFFF; cmd_dat = 16'hDEAD;
   endtask

   task automatic waitRsp(output int n);
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #3;
      nVec++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, rsp_valid, rsp_err, rsp_dat} !== '0) begin
         nFail++;
         $display("[TB] FAIL reset_outputs: cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h rv=%b re=%b rd=%h, expected all 0",
                  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, rsp_valid, rsp_err, rsp_dat);
      end
      nVec++;
      if (cmd_ready !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL reset_cmd_ready: got %b, expected 1", cmd_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_word_rw;
      int n;
      slaveMode = 0;
      applyStimulus(1'b1, 1'b0, 24'h000010, 16'hBEEF);
      nVec++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, cmd_ready} !== {5'b11111, 24'h000010, 16'hBEEF, 1'b0}) begin
         nFail++;
         $display("[TB] FAIL word_write_bus: cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h rdy=%b, expected 1 1 1 11 000010 beef 0",
                  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, cmd_ready);
      end
      waitRsp(n);
      nVec++;
      if ({n[7:0], rsp_err, rsp_dat, wb_cyc_o} !== {8'd2, 1'b0, 16'h0000, 1'b0}) begin
         nFail++;
         $display("[TB] FAIL word_write_rsp: lat=%0d err=%b dat=%h cyc=%b, expected 2 0 0000 0", n, rsp_err, rsp_dat, wb_cyc_o);
      end
      @(negedge clk);
      nVec++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         nFail++;
         $display("[TB] FAIL rsp_release: rsp_valid=%b cmd_ready=%b, expected 0 1", rsp_valid, cmd_ready);
      end
      applyStimulus(1'b0, 1'b0, 24'h000010, 16'h0000);
      nVec++;
      if ({wb_we_o, wb_sel_o} !== 3'b011) begin
         nFail++;
         $display("[TB] FAIL word_read_bus: we=%b sel=%b, expected 0 11", wb_we_o, wb_sel_o);
      end
      waitRsp(n);
      nVec++;
      if ({n[7:0], rsp_err, rsp_dat} !== {8'd2, 1'b0, 16'hBEEF}) begin
         nFail++;
         $display("[TB] FAIL word_read_rsp: lat=%0d err=%b dat=%h, expected 2 0 beef", n, rsp_err, rsp_dat);
      end
      @(negedge clk);
   endtask

   task automatic test_byte;
      int n;
      applyStimulus(1'b1, 1'b1, 24'h000011, 16'h125A);
      nVec++;
      if ({wb_sel_o, wb_dat_o, wb_adr_o} !== {2'b10, 16'h5A5A, 24'h000011}) begin
         nFail++;
         $display("[TB] FAIL byte_write_bus: sel=%b dat=%h adr=%h, expected 10 5a5a 000011", wb_sel_o, wb_dat_o, wb_adr_o);
      end
      waitRsp(n);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 24'h000010, 16'h0000);
      waitRsp(n);
      nVec++;
      if ({rsp_err, rsp_dat} !== {1'b0, 16'h5AEF}) begin
         nFail++;
         $display("[TB] FAIL word_read_merged: err=%b dat=%h, expected 0 5aef", rsp_err, rsp_dat);
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 24'h000010, 16'h0000);
      nVec++;
      if (wb_sel_o !== 2'b01) begin
         nFail++;
         $display("[TB] FAIL byte_read_sel: got %b, expected 01", wb_sel_o);
      end
      waitRsp(n);
      nVec++;
      if ({rsp_err, rsp_dat} !== {1'b0, 16'h00EF}) begin
         nFail++;
         $display("[TB] FAIL byte_read_lo: err=%b dat=%h, expected 0 00ef", rsp_err, rsp_dat);
      end
      @(negedge clk);
   endtask

   task automatic test_misaligned;
      int n, start;
      start = cycCount;
      applyStimulus(1'b0, 1'b0, 24'h000013, 16'h0000);
      waitRsp(n);
      nVec++;
      if ({n[7:0], rsp_err, rsp_dat} !== {8'd0, 1'b1, 16'h0000}) begin
         nFail++;
         $display("[TB] FAIL misaligned_rsp: lat=%0d err=%b dat=%h, expected 0 1 0000", n, rsp_err, rsp_dat);
      end
      nVec++;
      if (cycCount - start !== 0) begin
         nFail++;
         $display("[TB] FAIL misaligned_cyc: cyc high %0d cycles, expected 0", cycCount - start);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int n, start;
      slaveMode = 1;
      start = cycCount;
      applyStimulus(1'b0, 1'b0, 24'h000020, 16'h0000);
      waitRsp(n);
      nVec++;
      if ({n[7:0], rsp_err, rsp_dat} !== {8'd16, 1'b1, 16'h0000}) begin
         nFail++;
         $display("[TB] FAIL timeout_rsp: lat=%0d err=%b dat=%h, expected 16 1 0000", n, rsp_err, rsp_dat);
      end
      nVec++;
      if (cycCount - start !== 16) begin
         nFail++;
         $display("[TB] FAIL timeout_cyc: cyc high %0d cycles, expected 16", cycCount - start);
      end
      @(negedge clk);
      slaveMode = 0;
      applyStimulus(1'b0, 1'b1, 24'h000011, 16'h0000);
      nVec++;
      if (wb_sel_o !== 2'b10) begin
         nFail++;
         $display("[TB] FAIL byte_read_hi_sel: got %b, expected 10", wb_sel_o);
      end
      waitRsp(n);
      nVec++;
      if ({n[7:0], rsp_err, rsp_dat} !== {8'd2, 1'b0, 16'h005A}) begin
         nFail++;
         $display("[TB] FAIL after_timeout_rsp: lat=%0d err=%b dat=%h, expected 2 0 005a", n, rsp_err, rsp_dat);
      end
      @(negedge clk);
   endtask

   task automatic test_back_pressure;
      int n;
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 24'h000010, 16'h0000);
      waitRsp(n);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         nVec++;
         if ({rsp_valid, rsp_err, rsp_dat, cmd_ready} !== {1'b1, 1'b0, 16'h5AEF, 1'b0}) begin
            nFail++;
            $display("[TB] FAIL hold_%0d: valid=%b err=%b dat=%h rdy=%b, expected 1 0 5aef 0",
                     i, rsp_valid, rsp_err, rsp_dat, cmd_ready);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      nVec++;
      if (rsp_valid !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL hold_release: rsp_valid=%b, expected 0", rsp_valid);
      end
   endtask

   task automatic test_err;
      int n;
      slaveMode = 2;
      applyStimulus(1'b0, 1'b0, 24'h000010, 16'h0000);
      waitRsp(n);
      nVec++;
      if ({n[7:0], rsp_err, rsp_dat} !== {8'd2, 1'b1, 16'h0000}) begin
         nFail++;
         $display("[TB] FAIL ack_err_rsp: lat=%0d err=%b dat=%h, expected 2 1 0000", n, rsp_err, rsp_dat);
      end
      @(negedge clk);
      slaveMode = 0;
   endtask

   task automatic test_async_reset;
      int n;
      slaveMode = 1;
      applyStimulus(1'b0, 1'b0, 24'h000010, 16'h0000);
      @(negedge clk);
      nVec++;
      if (wb_cyc_o !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL pre_reset_cyc: got %b, expected 1", wb_cyc_o);
      end
      #2 rst = 1'b1;
      #1;
      nVec++;
      if ({wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready} !== 4'b0001) begin
         nFail++;
         $display("[TB] FAIL async_reset: cyc=%b stb=%b rv=%b rdy=%b, expected 0 0 0 1",
                  wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      slaveMode = 0;
      applyStimulus(1'b0, 1'b0, 24'h000010, 16'h0000);
      waitRsp(n);
      nVec++;
      if ({n[7:0], rsp_err, rsp_dat} !== {8'd2, 1'b0, 16'h5AEF}) begin
         nFail++;
         $display("[TB] FAIL post_reset_read: lat=%0d err=%b dat=%h, expected 2 0 5aef", n, rsp_err, rsp_dat);
      end
      @(negedge clk);
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_byte = 1'b0;
      cmd_adr = '0; cmd_dat = '0; rsp_ready = 1'b1;
      test_reset();
      test_word_rw();
      test_byte();
      test_misaligned();
      test_timeout();
      test_back_pressure();
      test_err();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
